// File: rtl/mul_div_if.sv
// Request/response bundle between an issuing pipeline stage and the iterative
// multiply/divide unit; the unit's write side maps onto register-file port 3.
interface mul_div_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) ();
   logic                     start;
   logic [2:0]               funct3;
   logic [DATA_WIDTH-1:0]    rs1_val;
   logic [DATA_WIDTH-1:0]    rs2_val;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic                     busy;
   logic                     done;
   logic [DATA_WIDTH-1:0]    result;
   logic [ADDRESS_WIDTH-1:0] rd_out;
   logic                     we;

   modport master (
      output start, funct3, rs1_val, rs2_val, rd_addr,
      input  busy, done, result, rd_out, we
   );

   modport slave (
      input  start, funct3, rs1_val, rs2_val, rd_addr,
      output busy, done, result, rd_out, we
   );
endinterface

// File: rtl/mul_div_unit.sv
// Fixed-latency RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one iteration per cycle, sign fix-up at DONE.
module mul_div_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input logic      clk,
   input logic      rst,
   mul_div_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
   typedef enum logic [2:0] {
      F_MUL, F_MULH, F_MULHSU, F_MULHU, F_DIV, F_DIVU, F_REM, F_REMU
   } funct_e;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q;
   funct_e                   op_q;
   logic                     neg_a_q, neg_b_q, div_zero_q;
   logic [W-1:0]             opnd_q;   // multiplicand or divisor magnitude
   logic [W-1:0]             acc_q;    // product high half or partial remainder
   logic [W-1:0]             lo_q;     // multiplier/product low half or dividend/quotient
   logic [ADDRESS_WIDTH-1:0] rd_q, rd_out_q;
   logic [W-1:0]             result_q;

   // Operand conditioning at capture time
   funct_e       f_in;
   logic         a_sgn, b_sgn, neg_a_in, neg_b_in;
   logic [W-1:0] mag_a, mag_b;

   always_comb begin
      f_in     = funct_e'(bus.funct3);
      a_sgn    = f_in inside {F_MULH, F_MULHSU, F_DIV, F_REM};
      b_sgn    = f_in inside {F_MULH, F_DIV, F_REM};
      neg_a_in = a_sgn & bus.rs1_val[W-1];
      neg_b_in = b_sgn & bus.rs2_val[W-1];
      mag_a    = neg_a_in ? -bus.rs1_val : bus.rs1_val;
      mag_b    = neg_b_in ? -bus.rs2_val : bus.rs2_val;
   end

   // One shift-add or restoring-divide step
   logic [W:0]   mul_sum, div_shift;
   logic         div_ge;
   logic [W-1:0] acc_d, lo_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      acc_d     = acc_q;
      lo_d      = lo_q;
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {acc_q, lo_q[W-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      if (op_q[2]) begin
         acc_d = div_ge ? (div_shift[W-1:0] - opnd_q) : div_shift[W-1:0];
         lo_d  = {lo_q[W-2:0], div_ge};
      end else begin
         {acc_d, lo_d} = {mul_sum, lo_q[W-1:1]};
      end
   end

   // Sign correction and result selection, valid while in DONE
   logic [2*W-1:0] prod_s;
   logic [W-1:0]   quo_s, rem_s, final_res;

   always_comb begin
      prod_s    = (neg_a_q ^ neg_b_q) ? -{acc_q, lo_q} : {acc_q, lo_q};
      quo_s     = div_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_q : lo_q);
      rem_s     = neg_a_q ? -acc_q : acc_q;
      final_res = prod_s[W-1:0];
      case (op_q)
         F_MUL:                      final_res = prod_s[W-1:0];
         F_MULH, F_MULHSU, F_MULHU:  final_res = prod_s[2*W-1:W];
         F_DIV, F_DIVU:              final_res = quo_s;
         F_REM, F_REMU:              final_res = rem_s;
         default:                    final_res = prod_s[W-1:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_CALC;
         S_CALC:  if (cnt_q == CW'(W - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= F_MUL;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         div_zero_q <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         rd_q       <= '0;
         rd_out_q   <= '0;
         result_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (bus.start) begin
               op_q       <= f_in;
               neg_a_q    <= neg_a_in;
               neg_b_q    <= neg_b_in;
               div_zero_q <= (bus.rs2_val == '0);
               opnd_q     <= f_in[2] ? mag_b : mag_a;
               lo_q       <= f_in[2] ? mag_a : mag_b;
               acc_q      <= '0;
               cnt_q      <= '0;
               rd_q       <= bus.rd_addr;
            end
            S_CALC: begin
               acc_q <= acc_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + CW'(1);
            end
            S_DONE: begin
               result_q <= final_res;
               rd_out_q <= rd_q;
            end
            default: ;
         endcase
      end
   end

   logic in_done;
   logic [ADDRESS_WIDTH-1:0] rd_sel;

   assign in_done    = (state_q == S_DONE);
   assign rd_sel     = in_done ? rd_q : rd_out_q;
   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = in_done;
   assign bus.result = in_done ? final_res : result_q;
   assign bus.rd_out = rd_sel;
   assign bus.we     = in_done && (rd_sel != '0);
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, corner-case results, busy-start
// rejection, back-to-back issue and asynchronous reset mid-operation.
module tb_mul_div_unit;
   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   mul_div_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

   mul_div_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents a request during one cycle; returns 1 ns into the cycle after acceptance.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.funct3  = f;
      bus.rs1_val = a;
      bus.rs2_val = b;
      bus.rd_addr = rd;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Walks cycles 1..34 after acceptance; optionally pulses a second start at inj_cycle.
   task automatic expect_done(input string tag, input logic [31:0] exp_res,
                              input logic [4:0] exp_rd, input logic exp_we, input int inj_cycle);
      int early = 0;
      for (int c = 1; c < 33; c++) begin
         if (bus.done || bus.we) early++;
         if (c == inj_cycle) begin
            bus.start   = 1'b1;
            bus.funct3  = 3'b000;
            bus.rs1_val = 32'd9;
            bus.rs2_val = 32'd9;
            bus.rd_addr = 5'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      check({tag, " early_done"}, 64'(early), 64'd0);
      check({tag, " done@33"}, 64'(bus.done), 64'd1);
      check({tag, " result"}, 64'(bus.result), 64'(exp_res));
      check({tag, " rd_out"}, 64'(bus.rd_out), 64'(exp_rd));
      check({tag, " we"}, 64'(bus.we), 64'(exp_we));
      @(posedge clk);
      #1;
      check({tag, " done@34"}, 64'(bus.done), 64'd0);
      check({tag, " busy@34"}, 64'(bus.busy), 64'd0);
      check({tag, " result_hold"}, 64'(bus.result), 64'(exp_res));
   endtask

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.funct3  = 3'b000;
      bus.rs1_val = '0;
      bus.rs2_val = '0;
      bus.rd_addr = '0;
      #3;
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset we", 64'(bus.we), 64'd0);
      check("reset result", 64'(bus.result), 64'd0);
      check("reset rd_out", 64'(bus.rd_out), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
      check("mul busy@1", 64'(bus.busy), 64'd1);
      expect_done("mul 7*-3", 32'hFFFF_FFEB, 5'd5, 1'b1, 0);

      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
      expect_done("mulh min*min", 32'h4000_0000, 5'd1, 1'b1, 0);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      expect_done("mulhu max*max", 32'hFFFF_FFFE, 5'd2, 1'b1, 0);
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      expect_done("mulhsu -1*max", 32'hFFFF_FFFF, 5'd3, 1'b1, 0);

      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
      expect_done("div overflow", 32'h8000_0000, 5'd4, 1'b1, 0);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
      expect_done("rem overflow", 32'h0000_0000, 5'd6, 1'b1, 0);
      issue(3'b101, 32'd100, 32'd0, 5'd8);
      expect_done("divu by 0", 32'hFFFF_FFFF, 5'd8, 1'b1, 0);
      issue(3'b111, 32'd100, 32'd0, 5'd10);
      expect_done("remu by 0", 32'd100, 5'd10, 1'b1, 0);
      issue(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd11);
      expect_done("div -7 by 0", 32'hFFFF_FFFF, 5'd11, 1'b1, 0);
      issue(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd12);
      expect_done("rem -7 by 0", 32'hFFFF_FFF9, 5'd12, 1'b1, 0);
      issue(3'b111, 32'd100, 32'd7, 5'd13);
      expect_done("remu 100/7", 32'd2, 5'd13, 1'b1, 0);
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd14);
      expect_done("div -7/2", 32'hFFFF_FFFD, 5'd14, 1'b1, 0);
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd15);
      expect_done("rem -7/2", 32'hFFFF_FFFF, 5'd15, 1'b1, 0);

      issue(3'b101, 32'd10, 32'd3, 5'd0);
      expect_done("divu rd0", 32'd3, 5'd0, 1'b0, 0);

      // Second start at cycle 10 must be ignored; the next issue lands in cycle 34.
      issue(3'b000, 32'd3, 32'd4, 5'd16);
      expect_done("mul busy-start", 32'd12, 5'd16, 1'b1, 10);
      issue(3'b000, 32'd5, 32'd5, 5'd17);
      expect_done("mul back2back", 32'd25, 5'd17, 1'b1, 0);

      // Asynchronous reset during cycle 15 of a divide.
      issue(3'b101, 32'd100, 32'd7, 5'd18);
      repeat (14) @(posedge clk);
      #2;
      check("pre-rst busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      #1;
      check("rst async busy", 64'(bus.busy), 64'd0);
      check("rst async done", 64'(bus.done), 64'd0);
      check("rst async result", 64'(bus.result), 64'd0);
      check("rst async rd_out", 64'(bus.rd_out), 64'd0);
      bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("start in rst busy", 64'(bus.busy), 64'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) break;
      end
      check("post-rst no done", 64'(bus.done), 64'd0);
      check("post-rst idle", 64'(bus.busy), 64'd0);
      issue(3'b000, 32'd6, 32'd7, 5'd7);
      expect_done("mul after rst", 32'd42, 5'd7, 1'b1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
